// File: rtl/serial_sub_pkg.sv
// serial_sub_pkg: definitions shared by the bit-serial subtractor.
//   - state_e       : FSM state encoding (IDLE=0, RUN=1)
//   - DEFAULT_WIDTH : default operand/result width
//   - cnt_width()   : bit counter width able to hold the values 0..width
package serial_sub_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

    // The counter must reach WIDTH itself after the last RUN cycle.
    function automatic int cnt_width(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/serial_subtractor_full_subtractor.sv
// full_subtractor: 1-bit combinational full-subtractor cell, the inverse of
// full_adder. Port order mirrors full_adder: outputs first.
//   diff : a ^ b ^ bin
//   bout : borrow out, set when a < b + bin
//   a    : minuend bit
//   b    : subtrahend bit
//   bin  : borrow in
module full_subtractor (
    output logic diff,
    output logic bout,
    input  logic a,
    input  logic b,
    input  logic bin
);

    assign diff = a ^ b ^ bin;
    assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// serial_subtractor: LSB-first bit-serial a - b - bin over WIDTH cycles using
// one full_subtractor cell and a registered borrow.
//   clk   : rising-edge clock
//   rst   : synchronous active-high reset, priority over everything
//   start : request, sampled only while idle
//   a, b  : minuend / subtrahend, captured on the accepted start
//   bin   : borrow-in, captured on the accepted start
//   busy  : operation in flight
//   done  : one-cycle pulse when diff/bout/ovf are updated
//   diff  : (a - b - bin) mod 2^WIDTH
//   bout  : final borrow (unsigned a < b + bin)
//   ovf   : two's-complement overflow of the subtraction
module serial_subtractor
    import serial_sub_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             bout,
    output logic             ovf
);

    localparam int CW = cnt_width(WIDTH);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_sr_q, a_sr_d;
    logic [WIDTH-1:0] b_sr_q, b_sr_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic             br_q, br_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    // Operand sign bits are kept because the shift registers lose them.
    logic             a_msb_q, a_msb_d;
    logic             b_msb_q, b_msb_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic             bout_q, bout_d;
    logic             ovf_q, ovf_d;

    logic             cell_d_s;
    logic             cell_bout_s;
    logic             last_s;

    full_subtractor u_cell (
        .diff (cell_d_s),
        .bout (cell_bout_s),
        .a    (a_sr_q[0]),
        .b    (b_sr_q[0]),
        .bin  (br_q)
    );

    assign last_s = (state_q == RUN) && (cnt_q == CW'(WIDTH - 1));

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = RUN;
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                if (last_s) begin
                    state_d = IDLE;
                end else begin
                    state_d = RUN;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Datapath and output-register next values.
    always_comb begin
        a_sr_d  = a_sr_q;
        b_sr_d  = b_sr_q;
        res_d   = res_q;
        br_d    = br_q;
        cnt_d   = cnt_q;
        a_msb_d = a_msb_q;
        b_msb_d = b_msb_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        diff_d  = diff_q;
        bout_d  = bout_q;
        ovf_d   = ovf_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    a_sr_d  = a;
                    b_sr_d  = b;
                    br_d    = bin;
                    cnt_d   = '0;
                    a_msb_d = a[WIDTH-1];
                    b_msb_d = b[WIDTH-1];
                    busy_d  = 1'b1;
                end else begin
                    busy_d  = 1'b0;
                end
            end
            RUN: begin
                a_sr_d = {1'b0, a_sr_q[WIDTH-1:1]};
                b_sr_d = {1'b0, b_sr_q[WIDTH-1:1]};
                res_d  = {cell_d_s, res_q[WIDTH-1:1]};
                br_d   = cell_bout_s;
                cnt_d  = cnt_q + CW'(1);
                if (last_s) begin
                    // The final bit is the result MSB and feeds ovf directly.
                    diff_d = {cell_d_s, res_q[WIDTH-1:1]};
                    bout_d = cell_bout_s;
                    ovf_d  = (a_msb_q != b_msb_q) && (cell_d_s != a_msb_q);
                    done_d = 1'b1;
                    busy_d = 1'b0;
                end else begin
                    busy_d = 1'b1;
                end
            end
            default: begin
                busy_d = 1'b0;
            end
        endcase
    end

    // Datapath and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_sr_q  <= '0;
            b_sr_q  <= '0;
            res_q   <= '0;
            br_q    <= 1'b0;
            cnt_q   <= '0;
            a_msb_q <= 1'b0;
            b_msb_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            diff_q  <= '0;
            bout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            a_sr_q  <= a_sr_d;
            b_sr_q  <= b_sr_d;
            res_q   <= res_d;
            br_q    <= br_d;
            cnt_q   <= cnt_d;
            a_msb_q <= a_msb_d;
            b_msb_q <= b_msb_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            diff_q  <= diff_d;
            bout_q  <= bout_d;
            ovf_q   <= ovf_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign diff = diff_q;
    assign bout = bout_q;
    assign ovf  = ovf_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// tb_serial_subtractor: directed checks of serial_subtractor at WIDTH=8 plus
// an exhaustive back-to-back sweep of a WIDTH=4 instance.
module tb_serial_subtractor;

    logic       clk = 1'b0;
    logic       rst;
    logic       start8, bin8, busy8, done8, bout8, ovf8;
    logic [7:0] a8, b8, diff8;
    logic       start4, bin4, busy4, done4, bout4, ovf4;
    logic [3:0] a4, b4, diff4;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    serial_subtractor #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8), .bin(bin8),
        .busy(busy8), .done(done8), .diff(diff8), .bout(bout8), .ovf(ovf8)
    );

    serial_subtractor #(.WIDTH(4)) dut4 (
        .clk(clk), .rst(rst), .start(start4), .a(a4), .b(b4), .bin(bin4),
        .busy(busy4), .done(done4), .diff(diff4), .bout(bout4), .ovf(ovf4)
    );

    // Advance past the next rising edge; outputs are then settled.
    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Issue one 8-bit operation and wait for done. lat counts edges after
    // the accept edge (8 expected); -1 when done never came.
    task automatic run8(input logic [7:0] av, input logic [7:0] bv, input logic bv_in,
                        output int lat);
        a8 = av; b8 = bv; bin8 = bv_in; start8 = 1'b1;
        tick();
        start8 = 1'b0;
        lat = 0;
        while (!done8 && lat < 20) begin
            tick();
            lat++;
        end
        if (!done8) lat = -1;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        tick(); tick();
        rst = 1'b0;
        checks++; if (busy8 !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy8); end
        checks++; if (done8 !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", done8); end
        checks++; if (diff8 !== 8'h00) begin failures++; $display("FAIL reset_diff got=%h exp=00", diff8); end
        checks++; if ({bout8, ovf8} !== 2'b00) begin failures++; $display("FAIL reset_bout_ovf got=%b exp=00", {bout8, ovf8}); end
    endtask

    task automatic test_basic;
        int n;
        a8 = 8'h5A; b8 = 8'h3C; bin8 = 1'b0; start8 = 1'b1;
        tick();
        start8 = 1'b0;
        checks++; if (busy8 !== 1'b1) begin failures++; $display("FAIL basic_busy_at_accept got=%b exp=1", busy8); end
        n = 0;
        while (!done8 && n < 20) begin tick(); n++; end
        checks++; if (n !== 8) begin failures++; $display("FAIL basic_latency got=%0d exp=8", n); end
        checks++; if (busy8 !== 1'b0) begin failures++; $display("FAIL basic_busy_at_done got=%b exp=0", busy8); end
        checks++; if ({diff8, bout8, ovf8} !== {8'h1E, 1'b0, 1'b0})
            begin failures++; $display("FAIL basic_result got=%h/%b/%b exp=1e/0/0", diff8, bout8, ovf8); end
        tick();
        checks++; if (done8 !== 1'b0) begin failures++; $display("FAIL basic_done_width got=%b exp=0", done8); end
        checks++; if (diff8 !== 8'h1E) begin failures++; $display("FAIL basic_hold got=%h exp=1e", diff8); end
    endtask

    task automatic test_borrow;
        int n;
        run8(8'h00, 8'h01, 1'b0, n);
        checks++; if (n !== 8) begin failures++; $display("FAIL borrow1_latency got=%0d exp=8", n); end
        checks++; if ({diff8, bout8, ovf8} !== {8'hFF, 1'b1, 1'b0})
            begin failures++; $display("FAIL borrow1_result got=%h/%b/%b exp=ff/1/0", diff8, bout8, ovf8); end
        tick();
        run8(8'h10, 8'h0F, 1'b1, n);
        checks++; if ({diff8, bout8, ovf8} !== {8'h00, 1'b0, 1'b0})
            begin failures++; $display("FAIL borrow_in_result got=%h/%b/%b exp=00/0/0", diff8, bout8, ovf8); end
        tick();
    endtask

    task automatic test_overflow;
        int n;
        run8(8'h80, 8'h01, 1'b0, n);
        checks++; if ({diff8, bout8, ovf8} !== {8'h7F, 1'b0, 1'b1})
            begin failures++; $display("FAIL ovf_neg_result got=%h/%b/%b exp=7f/0/1", diff8, bout8, ovf8); end
        tick();
        run8(8'h7F, 8'hFF, 1'b0, n);
        checks++; if ({diff8, bout8, ovf8} !== {8'h80, 1'b1, 1'b1})
            begin failures++; $display("FAIL ovf_pos_result got=%h/%b/%b exp=80/1/1", diff8, bout8, ovf8); end
        tick();
    endtask

    task automatic test_ignore_start;
        int ndone = 0;
        int edge_at = -1;
        logic [7:0] d_at = 8'h00;
        logic b_at = 1'b0;
        a8 = 8'h5A; b8 = 8'h3C; bin8 = 1'b0; start8 = 1'b1;
        tick();                                   // edge 0
        start8 = 1'b0;
        tick(); tick();                           // edges 1, 2
        a8 = 8'hFF; b8 = 8'h00; bin8 = 1'b1; start8 = 1'b1;
        tick();                                   // edge 3
        start8 = 1'b0; a8 = 8'h00; b8 = 8'h00; bin8 = 1'b0;
        checks++; if (diff8 !== 8'h80) begin failures++; $display("FAIL ignore_hold_during_run got=%h exp=80", diff8); end
        for (int e = 4; e <= 22; e++) begin
            tick();
            if (done8) begin
                ndone++;
                if (edge_at < 0) begin edge_at = e; d_at = diff8; b_at = bout8; end
            end
        end
        checks++; if (ndone !== 1) begin failures++; $display("FAIL ignore_done_count got=%0d exp=1", ndone); end
        checks++; if (edge_at !== 8) begin failures++; $display("FAIL ignore_done_edge got=%0d exp=8", edge_at); end
        checks++; if ({d_at, b_at} !== {8'h1E, 1'b0})
            begin failures++; $display("FAIL ignore_result got=%h/%b exp=1e/0", d_at, b_at); end
    endtask

    task automatic test_reset_mid;
        int n;
        int ndone = 0;
        a8 = 8'h5A; b8 = 8'h3C; bin8 = 1'b0; start8 = 1'b1;
        tick();                                   // edge 0
        start8 = 1'b0;
        tick(); tick(); tick();                   // edges 1..3
        rst = 1'b1;
        tick();                                   // edge 4
        rst = 1'b0;
        checks++; if ({busy8, done8, diff8, bout8, ovf8} !== 12'h000)
            begin failures++; $display("FAIL rstmid_outputs got=%b/%b/%h/%b/%b exp=0/0/00/0/0", busy8, done8, diff8, bout8, ovf8); end
        for (int e = 0; e < 12; e++) begin
            tick();
            if (done8) ndone++;
        end
        checks++; if (ndone !== 0) begin failures++; $display("FAIL rstmid_no_done got=%0d exp=0", ndone); end
        run8(8'h80, 8'h01, 1'b0, n);
        checks++; if (n !== 8) begin failures++; $display("FAIL rstmid_restart_latency got=%0d exp=8", n); end
        checks++; if ({diff8, bout8, ovf8} !== {8'h7F, 1'b0, 1'b1})
            begin failures++; $display("FAIL rstmid_restart_result got=%h/%b/%b exp=7f/0/1", diff8, bout8, ovf8); end
        tick();
    endtask

    // start held high; next operands appear in each done cycle. The accept
    // edge follows the done edge, so waits count WIDTH+1 edges per operation
    // (for the first one that includes the initial accept edge).
    task automatic test_back_to_back;
        logic [7:0] ta [4] = '{8'h5A, 8'h00, 8'h80, 8'h33};
        logic [7:0] tb [4] = '{8'h3C, 8'h01, 8'h01, 8'h44};
        logic       tc [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
        logic [7:0] td [4] = '{8'h1E, 8'hFF, 8'h7F, 8'hEE};
        int n;
        start8 = 1'b1;
        a8 = ta[0]; b8 = tb[0]; bin8 = tc[0];
        for (int i = 0; i < 4; i++) begin
            n = 0;
            do begin tick(); n++; end while (!done8 && n < 30);
            checks++; if (n !== 9) begin failures++; $display("FAIL b2b_gap[%0d] got=%0d exp=9", i, n); end
            checks++; if (diff8 !== td[i]) begin failures++; $display("FAIL b2b_diff[%0d] got=%h exp=%h", i, diff8, td[i]); end
            if (i < 3) begin
                a8 = ta[i+1]; b8 = tb[i+1]; bin8 = tc[i+1];
            end else begin
                start8 = 1'b0;
            end
        end
        tick(); tick();
        checks++; if (busy8 !== 1'b0) begin failures++; $display("FAIL b2b_idle_after got=%b exp=0", busy8); end
    endtask

    task automatic test_sweep4;
        int n, ea, eb, ec, sa, sb, sr;
        logic [3:0] exp_d;
        logic exp_b, exp_o;
        start4 = 1'b1;
        for (int k = 0; k < 512; k++) begin
            ea = k & 15; eb = (k >> 4) & 15; ec = (k >> 8) & 1;
            a4 = 4'(ea); b4 = 4'(eb); bin4 = 1'(ec);
            exp_d = 4'((ea - eb - ec) & 15);
            exp_b = (ea < eb + ec);
            sa = (ea >= 8) ? ea - 16 : ea;
            sb = (eb >= 8) ? eb - 16 : eb;
            sr = sa - sb - ec;
            exp_o = (sr < -8) || (sr > 7);
            n = 0;
            do begin tick(); n++; end while (!done4 && n < 20);
            if (k == 511) start4 = 1'b0;
            checks++; if (n !== 5) begin failures++; $display("FAIL sweep4_gap a=%0d b=%0d bin=%0d got=%0d exp=5", ea, eb, ec, n); end
            checks++; if ({diff4, bout4, ovf4} !== {exp_d, exp_b, exp_o})
                begin failures++; $display("FAIL sweep4_result a=%0d b=%0d bin=%0d got=%h/%b/%b exp=%h/%b/%b",
                                           ea, eb, ec, diff4, bout4, ovf4, exp_d, exp_b, exp_o); end
        end
        tick();
    endtask

    initial begin
        rst = 1'b1;
        start8 = 1'b0; a8 = 8'h00; b8 = 8'h00; bin8 = 1'b0;
        start4 = 1'b0; a4 = 4'h0; b4 = 4'h0; bin4 = 1'b0;
        test_reset();
        test_basic();
        test_borrow();
        test_overflow();
        test_ignore_start();
        test_reset_mid();
        test_back_to_back();
        test_sweep4();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
